// File: rtl/sie_boundary_detector.sv
// rtl/sie_boundary_detector.sv - SIE ignition event detector on the boundary amplitude stream
//
// Purpose: tracks a slow EMA baseline of the (non-negative) boundary amplitude and
// declares an ignition event once the amplitude stays above thresh_on x baseline
// for ONSET_HOLD consecutive samples. The event ends when the amplitude drops
// below thresh_off x baseline (hysteresis) or after MAX_IGNITE samples, and is
// followed by REFRACT_CYCLES ignored samples.
//
// Optional feature macro: SIE_DURATION_STATS_EN (adds last_duration, timeout_flag).
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   clk_en              sample strobe; all state advances only when high
//   boundary_amplitude  signed Q(WIDTH-FRAC).FRAC amplitude sample
//   thresh_on           onset ratio, Q.FRAC
//   thresh_off          exit ratio, Q.FRAC (<= thresh_on)
//   ignition            high while IGNITED
//   ignition_pulse      one clk pulse on entry to IGNITED
//   det_state           0 WARMUP, 1 QUIET, 2 ONSET, 3 IGNITED, 4 REFRACT
//   baseline            current EMA baseline
//   peak_amp            peak amplitude of current or last ignition
//   event_count         ignitions since reset, saturating
//   last_duration       (macro) IGNITED length in samples of last event, saturating
//   timeout_flag        (macro) last event ended by timeout
//
// ONSET_HOLD is expected to be >= 2 (the first above-threshold sample only enters ONSET).

module sie_boundary_detector #(
  parameter int WIDTH          = 18,
  parameter int FRAC           = 14,
  parameter int BASE_SHIFT     = 6,
  parameter int WARMUP_CYCLES  = 64,
  parameter int ONSET_HOLD     = 8,
  parameter int MAX_IGNITE     = 1024,
  parameter int REFRACT_CYCLES = 32,
  parameter int MIN_BASE       = 164
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] boundary_amplitude,
  input  logic signed [WIDTH-1:0] thresh_on,
  input  logic signed [WIDTH-1:0] thresh_off,
  output logic                    ignition,
  output logic                    ignition_pulse,
  output logic [2:0]              det_state,
  output logic signed [WIDTH-1:0] baseline,
  output logic signed [WIDTH-1:0] peak_amp,
  output logic [15:0]             event_count
`ifdef SIE_DURATION_STATS_EN
  ,
  output logic [15:0]             last_duration,
  output logic                    timeout_flag
`endif
);

  localparam logic [2:0] ST_WARMUP  = 3'd0;
  localparam logic [2:0] ST_QUIET   = 3'd1;
  localparam logic [2:0] ST_ONSET   = 3'd2;
  localparam logic [2:0] ST_IGNITED = 3'd3;
  localparam logic [2:0] ST_REFRACT = 3'd4;

  // Wide enough for (amp <<< FRAC) and baseline*thresh with no truncation.
  localparam int PW = 2 * WIDTH + 2;

  localparam int WW = (WARMUP_CYCLES  > 1) ? $clog2(WARMUP_CYCLES)      : 1;
  localparam int HW = (ONSET_HOLD     > 1) ? $clog2(ONSET_HOLD)         : 1;
  localparam int DW = (MAX_IGNITE     > 1) ? $clog2(MAX_IGNITE)         : 1;
  localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ONSET_HOLD - 1);
  localparam logic [DW-1:0] DUR_LAST  = DW'(MAX_IGNITE - 1);
  localparam logic [RW-1:0] REF_LOAD  = RW'(REFRACT_CYCLES);
  localparam logic [WW-1:0] WW_ONE    = WW'(1);
  localparam logic [HW-1:0] HW_ONE    = HW'(1);
  localparam logic [DW-1:0] DW_ONE    = DW'(1);
  localparam logic [RW-1:0] RW_ONE    = RW'(1);

  localparam logic signed [WIDTH-1:0] MIN_BASE_V = WIDTH'(MIN_BASE);

  logic [WW-1:0] warm_cnt;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] dur_cnt;
  logic [RW-1:0] ref_cnt;

  // Negative amplitudes carry no ignition energy; treat them as zero.
  logic signed [WIDTH-1:0] amp;
  assign amp = boundary_amplitude[WIDTH-1] ? '0 : boundary_amplitude;

  // Ratio tests done as cross-multiplication so no division is needed.
  logic signed [PW-1:0] amp_scaled;
  logic signed [PW-1:0] on_prod;
  logic signed [PW-1:0] off_prod;
  logic                 above_on;
  logic                 below_off;

  assign amp_scaled = PW'(amp) <<< FRAC;
  assign on_prod    = PW'(baseline) * PW'(thresh_on);
  assign off_prod   = PW'(baseline) * PW'(thresh_off);
  assign above_on   = amp_scaled > on_prod;
  assign below_off  = amp_scaled < off_prod;

  // EMA step in WIDTH+1 bits; the arithmetic shift floors toward -inf, so a
  // decaying baseline always moves and is caught by the MIN_BASE floor.
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   step;
  logic signed [WIDTH:0]   ema_sum;
  logic signed [WIDTH-1:0] ema_next;
  logic signed [WIDTH-1:0] first_base;

  assign diff       = {amp[WIDTH-1], amp} - {baseline[WIDTH-1], baseline};
  assign step       = diff >>> BASE_SHIFT;
  assign ema_sum    = {baseline[WIDTH-1], baseline} + step;
  assign ema_next   = (ema_sum < $signed({1'b0, MIN_BASE_V})) ? MIN_BASE_V : ema_sum[WIDTH-1:0];
  assign first_base = (amp < MIN_BASE_V) ? MIN_BASE_V : amp;

`ifdef SIE_DURATION_STATS_EN
  // Samples spent IGNITED including the exiting one.
  logic [31:0] dur_len;
  assign dur_len = 32'(dur_cnt) + 32'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_state      <= ST_WARMUP;
      ignition       <= 1'b0;
      ignition_pulse <= 1'b0;
      baseline       <= '0;
      peak_amp       <= '0;
      event_count    <= '0;
      warm_cnt       <= '0;
      hold_cnt       <= '0;
      dur_cnt        <= '0;
      ref_cnt        <= '0;
`ifdef SIE_DURATION_STATS_EN
      last_duration  <= '0;
      timeout_flag   <= 1'b0;
`endif
    end else begin
      // The pulse is one clk wide regardless of the sample strobe.
      ignition_pulse <= 1'b0;
      if (clk_en) begin
        case (det_state)
          ST_WARMUP: begin
            baseline <= (warm_cnt == '0) ? first_base : ema_next;
            if (warm_cnt == WARM_LAST) begin
              det_state <= ST_QUIET;
            end else begin
              warm_cnt <= warm_cnt + WW_ONE;
            end
          end

          ST_QUIET: begin
            if (above_on) begin
              det_state <= ST_ONSET;
              hold_cnt  <= HW_ONE;
            end else begin
              baseline <= ema_next;
            end
          end

          ST_ONSET: begin
            if (above_on) begin
              if (hold_cnt == HOLD_LAST) begin
                det_state      <= ST_IGNITED;
                ignition       <= 1'b1;
                ignition_pulse <= 1'b1;
                peak_amp       <= amp;
                dur_cnt        <= '0;
                hold_cnt       <= '0;
                if (event_count != 16'hFFFF) begin
                  event_count <= event_count + 16'd1;
                end
`ifdef SIE_DURATION_STATS_EN
                timeout_flag <= 1'b0;
`endif
              end else begin
                hold_cnt <= hold_cnt + HW_ONE;
              end
            end else begin
              det_state <= ST_QUIET;
              hold_cnt  <= '0;
            end
          end

          ST_IGNITED: begin
            if (amp > peak_amp) begin
              peak_amp <= amp;
            end
            dur_cnt <= dur_cnt + DW_ONE;
            if (below_off || (dur_cnt == DUR_LAST)) begin
              det_state <= ST_REFRACT;
              ignition  <= 1'b0;
              ref_cnt   <= REF_LOAD;
`ifdef SIE_DURATION_STATS_EN
              last_duration <= (dur_len > 32'd65535) ? 16'hFFFF : dur_len[15:0];
              if (dur_cnt == DUR_LAST) begin
                timeout_flag <= 1'b1;
              end
`endif
            end
          end

          ST_REFRACT: begin
            // The sample that brings ref_cnt to zero is still ignored.
            if (ref_cnt <= RW_ONE) begin
              det_state <= ST_QUIET;
              ref_cnt   <= '0;
            end else begin
              ref_cnt <= ref_cnt - RW_ONE;
            end
          end

          default: begin
            det_state <= ST_WARMUP;
            ignition  <= 1'b0;
            warm_cnt  <= '0;
            hold_cnt  <= '0;
            dur_cnt   <= '0;
            ref_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sie_boundary_detector.sv
// tb/tb_sie_boundary_detector.sv - directed self-checking bench for sie_boundary_detector

module tb_sie_boundary_detector;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic signed [17:0] amp_in;
  logic signed [17:0] thr_on;
  logic signed [17:0] thr_off;
  logic               ignition;
  logic               ignition_pulse;
  logic [2:0]         det_state;
  logic signed [17:0] baseline;
  logic signed [17:0] peak_amp;
  logic [15:0]        event_count;
`ifdef SIE_DURATION_STATS_EN
  logic [15:0]        last_duration;
  logic               timeout_flag;
`endif

  int n_cmp;
  int n_err;

  sie_boundary_detector dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clk_en             (clk_en),
    .boundary_amplitude (amp_in),
    .thresh_on          (thr_on),
    .thresh_off         (thr_off),
    .ignition           (ignition),
    .ignition_pulse     (ignition_pulse),
    .det_state          (det_state),
    .baseline           (baseline),
    .peak_amp           (peak_amp),
    .event_count        (event_count)
`ifdef SIE_DURATION_STATS_EN
    ,
    .last_duration      (last_duration),
    .timeout_flag       (timeout_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int a);
    @(negedge clk);
    amp_in = 18'(a);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stall();
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    clk_en  = 1'b0;
    amp_in  = '0;
    thr_on  = 18'sd32768;
    thr_off = 18'sd24576;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", det_state, 0);
    chk("rst_ignition", ignition, 0);
    chk("rst_pulse", ignition_pulse, 0);
    chk("rst_baseline", baseline, 0);
    chk("rst_peak", peak_amp, 0);
    chk("rst_count", event_count, 0);
`ifdef SIE_DURATION_STATS_EN
    chk("rst_last_dur", last_duration, 0);
    chk("rst_timeout", timeout_flag, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Warmup: 64 samples in WARMUP, QUIET after the 64th
    for (int i = 0; i < 63; i++) begin
      step(1638);
      chk("warmup_state", det_state, 0);
      chk("warmup_ignition", ignition, 0);
    end
    step(1638);
    chk("warmup_done_state", det_state, 1);
    chk("warmup_baseline", baseline, 1638);

    // First ignition: 7 ONSET samples then IGNITED on the 8th
    for (int i = 0; i < 7; i++) begin
      step(4915);
      chk("onset1_state", det_state, 2);
      chk("onset1_pulse", ignition_pulse, 0);
    end
    step(4915);
    chk("ign1_state", det_state, 3);
    chk("ign1_ignition", ignition, 1);
    chk("ign1_pulse", ignition_pulse, 1);
    chk("ign1_count", event_count, 1);
    chk("ign1_baseline", baseline, 1638);
    chk("ign1_peak", peak_amp, 4915);

    // Hysteresis band holds IGNITED
    for (int i = 0; i < 20; i++) begin
      step(3000);
      chk("hyst_state", det_state, 3);
      chk("hyst_pulse", ignition_pulse, 0);
    end
    chk("hyst_peak", peak_amp, 4915);
    step(9000);
    chk("peak_state", det_state, 3);
    chk("peak_amp", peak_amp, 9000);
    step(2000);
    chk("exit1_state", det_state, 4);
    chk("exit1_ignition", ignition, 0);
    chk("exit1_peak", peak_amp, 9000);
`ifdef SIE_DURATION_STATS_EN
    chk("exit1_last_dur", last_duration, 22);
    chk("exit1_timeout", timeout_flag, 0);
`endif

    // Refractory: 32 samples ignored, baseline frozen
    for (int i = 0; i < 31; i++) begin
      step(8000);
      chk("refr1_state", det_state, 4);
    end
    step(8000);
    chk("refr1_done_state", det_state, 1);
    chk("refr1_baseline", baseline, 1638);
    chk("refr1_peak_hold", peak_amp, 9000);
    for (int i = 0; i < 7; i++) begin
      step(8000);
      chk("onset2_state", det_state, 2);
    end
    step(8000);
    chk("ign2_state", det_state, 3);
    chk("ign2_count", event_count, 2);
    chk("ign2_pulse", ignition_pulse, 1);
    chk("ign2_peak", peak_amp, 8000);
    step(2000);
    chk("exit2_state", det_state, 4);
`ifdef SIE_DURATION_STATS_EN
    chk("exit2_last_dur", last_duration, 1);
`endif
    for (int i = 0; i < 32; i++) step(1638);
    chk("refr2_done_state", det_state, 1);
    chk("refr2_peak_hold", peak_amp, 8000);

    // Glitch rejection
    for (int i = 0; i < 5; i++) begin
      step(4915);
      chk("glitch_state", det_state, 2);
    end
    step(1638);
    chk("glitch_back_state", det_state, 1);
    chk("glitch_pulse", ignition_pulse, 0);
    chk("glitch_count", event_count, 2);
    chk("glitch_baseline", baseline, 1638);

    // clk_en stall mid-ONSET
    for (int i = 0; i < 3; i++) step(4915);
    chk("stall_pre_state", det_state, 2);
    for (int i = 0; i < 10; i++) begin
      stall();
      chk("stall_state", det_state, 2);
      chk("stall_baseline", baseline, 1638);
    end
    for (int i = 0; i < 4; i++) begin
      step(4915);
      chk("stall_post_state", det_state, 2);
    end
    step(4915);
    chk("ign3_state", det_state, 3);
    chk("ign3_count", event_count, 3);

    // Timeout after 1024 IGNITED samples
    for (int i = 0; i < 1023; i++) begin
      step(8000);
      chk("timeout_hold_state", det_state, 3);
    end
    step(8000);
    chk("timeout_state", det_state, 4);
    chk("timeout_ignition", ignition, 0);
    chk("timeout_peak", peak_amp, 8000);
`ifdef SIE_DURATION_STATS_EN
    chk("timeout_flag_set", timeout_flag, 1);
    chk("timeout_last_dur", last_duration, 1024);
`endif
    for (int i = 0; i < 32; i++) step(8000);
    chk("refr3_done_state", det_state, 1);
    for (int i = 0; i < 7; i++) step(8000);
    chk("onset4_state", det_state, 2);
    step(8000);
    chk("ign4_state", det_state, 3);
    chk("ign4_count", event_count, 4);
    chk("ign4_pulse", ignition_pulse, 1);
`ifdef SIE_DURATION_STATS_EN
    chk("ign4_timeout_clr", timeout_flag, 0);
`endif
    stall();
    chk("pulse_clr_stall", ignition_pulse, 0);
    chk("pulse_clr_state", det_state, 3);
    chk("pulse_clr_ignition", ignition, 1);
    step(8000);
    step(8000);

    // Asynchronous reset mid-IGNITED
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_state", det_state, 0);
    chk("areset_ignition", ignition, 0);
    chk("areset_pulse", ignition_pulse, 0);
    chk("areset_baseline", baseline, 0);
    chk("areset_peak", peak_amp, 0);
    chk("areset_count", event_count, 0);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Negative input in QUIET decays baseline to the floor
    for (int i = 0; i < 64; i++) step(1638);
    chk("rewarm_state", det_state, 1);
    chk("rewarm_baseline", baseline, 1638);
    step(-500);
    chk("neg1_baseline", baseline, 1612);
    chk("neg1_state", det_state, 1);
    step(-500);
    chk("neg2_baseline", baseline, 1586);
    for (int i = 0; i < 298; i++) begin
      step(-500);
      chk("neg_floor_bound", (baseline >= 18'sd164), 1);
    end
    chk("neg_floor_baseline", baseline, 164);
    chk("neg_state", det_state, 1);
    chk("neg_count", event_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
